// File: rtl/if_fetch_pkg.sv
// Shared types and sizing for the TinyCPU instruction-fetch stage.
package if_fetch_pkg;

  localparam int unsigned REG_W      = 32;
  localparam int unsigned MAX_OUT    = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PEND_CNT_W = $clog2(MAX_OUT + 1);
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [REG_W-1:0] RESET_PC = 32'h8000_0000;
  localparam logic [REG_W-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_e;

  // One buffered fetch result handed to the IF/ID register
  typedef struct packed {
    logic [REG_W-1:0] pc;
    logic [REG_W-1:0] inst;
  } if_pair_t;

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: imem req/gnt/rvalid handshake plus the decode-side pair.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic             imem_req_o;
  logic [REG_W-1:0] imem_addr_o;
  logic             imem_gnt_i;
  logic             imem_rvalid_i;
  logic [REG_W-1:0] imem_rdata_i;
  logic             if_valid_o;
  logic [REG_W-1:0] if_pc_o;
  logic [REG_W-1:0] if_inst_o;
  logic             id_ready_i;

  modport master (
    output imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_inst_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_inst_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i
  );

endinterface

// File: rtl/if_fetch_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; flush wins over push/pop.
module if_fetch_sync_fifo #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_do_pop;
  logic             w_do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_do_pop  = pop_i && (r_cnt != '0);
  assign w_do_push = push_i && ((r_cnt != CNT_W'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign data_o  = r_mem[r_rd_ptr];
  assign count_o = r_cnt;

endmodule

// File: rtl/if_fetch.sv
// TinyCPU instruction fetch: owns the PC, keeps up to MAX_OUT imem requests in flight,
// pairs responses with their PC and buffers pairs for decode; redirects squash stale work.
module if_fetch
  import if_fetch_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             redirect_i,
  input  logic [REG_W-1:0] redirect_pc_i,
  if_fetch_if.master       bus
);

  fetch_state_e          r_state;
  fetch_state_e          w_state_nxt;
  logic [REG_W-1:0]      r_pc;
  logic [REG_W-1:0]      w_pc_nxt;
  logic [PEND_CNT_W-1:0] r_drop_cnt;
  logic [PEND_CNT_W-1:0] w_drop_nxt;
  logic [PEND_CNT_W-1:0] w_pend_cnt;
  logic [FIFO_CNT_W-1:0] w_out_cnt;
  logic [REG_W-1:0]      w_pend_pc;
  if_pair_t              w_push_pair;
  if_pair_t              w_head;
  logic                  w_issue;
  logic                  w_grant;
  logic                  w_resp;
  logic                  w_keep;
  logic                  w_out_pop;

  // Credit rule: every in-flight response already owns a slot in the output FIFO
  assign w_issue = (r_state != ST_RESET)
                && (w_pend_cnt < PEND_CNT_W'(MAX_OUT))
                && ((32'(w_pend_cnt) + 32'(w_out_cnt)) < FIFO_DEPTH)
                && !redirect_i;
  assign w_grant     = w_issue && bus.imem_gnt_i;
  assign w_resp      = bus.imem_rvalid_i && (w_pend_cnt != '0);
  assign w_keep      = w_resp && (r_drop_cnt == '0) && !redirect_i;
  assign w_out_pop   = bus.if_valid_o && bus.id_ready_i && !redirect_i;
  assign w_push_pair = '{pc: w_pend_pc, inst: bus.imem_rdata_i};

  if_fetch_sync_fifo #(.WIDTH(REG_W), .DEPTH(MAX_OUT)) u_pend_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_grant),
    .data_i  (r_pc),
    .pop_i   (w_resp),
    .flush_i (1'b0),
    .data_o  (w_pend_pc),
    .count_o (w_pend_cnt)
  );

  if_fetch_sync_fifo #(.WIDTH($bits(if_pair_t)), .DEPTH(FIFO_DEPTH)) u_out_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_keep),
    .data_i  (w_push_pair),
    .pop_i   (w_out_pop),
    .flush_i (redirect_i),
    .data_o  (w_head),
    .count_o (w_out_cnt)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_RESET;
      r_pc       <= RESET_PC;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_drop_cnt <= w_drop_nxt;
    end
  end

  // Redirect squashes everything still in flight, including a response arriving now
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_drop_nxt  = r_drop_cnt;
    if (redirect_i) begin
      w_pc_nxt   = {redirect_pc_i[REG_W-1:2], 2'b00};
      w_drop_nxt = w_pend_cnt - PEND_CNT_W'(w_resp);
    end else begin
      if (w_grant) w_pc_nxt = r_pc + REG_W'(4);
      if (w_resp && (r_drop_cnt != '0)) w_drop_nxt = r_drop_cnt - PEND_CNT_W'(1);
    end
    case (r_state)
      ST_RESET: w_state_nxt = ST_RUN;
      ST_RUN,
      ST_DROP:  w_state_nxt = (w_drop_nxt != '0) ? ST_DROP : ST_RUN;
      default:  w_state_nxt = ST_RESET;
    endcase
  end

  assign bus.imem_req_o  = w_issue;
  assign bus.imem_addr_o = r_pc;
  assign bus.if_valid_o  = (w_out_cnt != '0);
  assign bus.if_pc_o     = w_head.pc;
  assign bus.if_inst_o   = w_head.inst;

  a_rvalid_has_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.imem_rvalid_i |-> (w_pend_cnt != '0));

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed cycle table, then a reactive imem model with a stream scoreboard.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam logic [31:0] B = 32'h8000_0000;
  localparam logic [31:0] J = 32'hDEAD_BEEF;

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
  } mreq_t;

  logic        clk;
  logic        rst_ni;
  logic        redirect;
  logic [31:0] redirect_pc;
  if_fetch_if  bus();

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: stream of expected pairs and the memory's outstanding queue
  mreq_t       mq[$];
  int unsigned epoch;
  int unsigned held;
  int unsigned pops;
  logic [31:0] exp_issue;
  logic [31:0] exp_out;
  logic        last_req;

  if_fetch dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd,
                              input logic rdy, input logic red, input logic [31:0] rpc,
                              input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep);
    vec_t v;
    v.gnt = g; v.rv = rv; v.rdata = rd; v.rdy = rdy; v.redir = red; v.rpc = rpc;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_inst = inst_of(ep);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic red, input logic [31:0] rpc);
    bus.imem_gnt_i    = g;
    bus.imem_rvalid_i = rv;
    bus.imem_rdata_i  = rd;
    bus.id_ready_i    = rdy;
    redirect          = red;
    redirect_pc       = rpc;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req",   32'(bus.imem_req_o), 32'd0);
    chk("rst_addr",  bus.imem_addr_o,     B);
    chk("rst_valid", 32'(bus.if_valid_o), 32'd0);
    chk("rst_pc",    bus.if_pc_o,         32'd0);
    chk("rst_inst",  bus.if_inst_o,       32'd0);
  endtask

  // Asserts reset mid-stream (outputs must clear at once), clears the model, then releases
  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    #1;
    chk_reset_outputs();
    mq.delete();
    epoch = 0; held = 0; exp_issue = B; exp_out = B;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // One cycle against the reactive memory; percentages select gnt/rvalid/ready/redirect
  task automatic auto_cycle(input int unsigned p_gnt, input int unsigned p_rv,
                            input int unsigned p_rdy, input int unsigned p_red);
    logic g, rv, rdy, red, req, valid, exp_req;
    logic [31:0] rd, rpc, addr, pc, inst;
    mreq_t e;
    @(negedge clk);
    g   = ($urandom_range(99) < p_gnt);
    rv  = (mq.size() != 0) && ($urandom_range(99) < p_rv);
    rd  = rv ? inst_of(mq[0].addr) : 32'd0;
    rdy = ($urandom_range(99) < p_rdy);
    red = ($urandom_range(99) < p_red);
    rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
    drive(g, rv, rd, rdy, red, rpc);
    #1;
    req = bus.imem_req_o; addr = bus.imem_addr_o;
    valid = bus.if_valid_o; pc = bus.if_pc_o; inst = bus.if_inst_o;
    last_req = req;
    exp_req = (mq.size() < int'(MAX_OUT)) && ((mq.size() + int'(held)) < int'(FIFO_DEPTH)) && !red;
    chk("req", 32'(req), 32'(exp_req));
    chk("valid", 32'(valid), 32'(held != 0));
    if (req) chk("addr", addr, exp_issue);
    if (valid && rdy && !red) begin
      chk("out_pc", pc, exp_out);
      chk("out_inst", inst, inst_of(exp_out));
    end
    if (rv) begin
      e = mq.pop_front();
      if (e.epoch == epoch && !red) held++;
    end
    if (valid && rdy && !red && held > 0) begin
      held--;
      exp_out = exp_out + 32'd4;
      pops++;
    end
    if (req && g) begin
      mq.push_back('{addr: addr, epoch: epoch});
      exp_issue = exp_issue + 32'd4;
    end
    if (red) begin
      epoch++;
      held = 0;
      exp_issue = rpc & 32'hFFFF_FFFC;
      exp_out = exp_issue;
    end
  endtask

  initial begin
    vec_t vt[25];
    int unsigned p0;
    //            gnt  rv   rdata               rdy  red  rpc               req  addr              valid pc
    vt[0]  = mk(1'b0,1'b0,32'd0,             1'b0,1'b0,32'd0,           1'b0,B,                1'b0,32'd0);
    vt[1]  = mk(1'b1,1'b0,32'd0,             1'b0,1'b0,32'd0,           1'b1,B,                1'b0,32'd0);
    vt[2]  = mk(1'b1,1'b1,inst_of(B),        1'b0,1'b0,32'd0,           1'b1,B+32'h4,          1'b0,32'd0);
    vt[3]  = mk(1'b1,1'b1,inst_of(B+32'h4),  1'b1,1'b0,32'd0,           1'b1,B+32'h8,          1'b1,B);
    vt[4]  = mk(1'b0,1'b1,inst_of(B+32'h8),  1'b1,1'b0,32'd0,           1'b1,B+32'hC,          1'b1,B+32'h4);
    vt[5]  = mk(1'b0,1'b0,32'd0,             1'b0,1'b0,32'd0,           1'b1,B+32'hC,          1'b1,B+32'h8);
    vt[6]  = mk(1'b0,1'b0,32'd0,             1'b0,1'b0,32'd0,           1'b1,B+32'hC,          1'b1,B+32'h8);
    vt[7]  = mk(1'b1,1'b0,32'd0,             1'b0,1'b0,32'd0,           1'b1,B+32'hC,          1'b1,B+32'h8);
    vt[8]  = mk(1'b1,1'b1,inst_of(B+32'hC),  1'b0,1'b0,32'd0,           1'b1,B+32'h10,         1'b1,B+32'h8);
    vt[9]  = mk(1'b1,1'b0,32'd0,             1'b0,1'b0,32'd0,           1'b1,B+32'h14,         1'b1,B+32'h8);
    vt[10] = mk(1'b1,1'b0,32'd0,             1'b1,1'b1,B+32'h102,       1'b0,B+32'h18,         1'b1,B+32'h8);
    vt[11] = mk(1'b0,1'b1,J,                 1'b0,1'b0,32'd0,           1'b0,B+32'h100,        1'b0,32'd0);
    vt[12] = mk(1'b1,1'b1,J,                 1'b0,1'b0,32'd0,           1'b1,B+32'h100,        1'b0,32'd0);
    vt[13] = mk(1'b0,1'b1,inst_of(B+32'h100),1'b1,1'b0,32'd0,           1'b1,B+32'h104,        1'b0,32'd0);
    vt[14] = mk(1'b0,1'b0,32'd0,             1'b1,1'b0,32'd0,           1'b1,B+32'h104,        1'b1,B+32'h100);
    vt[15] = mk(1'b1,1'b0,32'd0,             1'b0,1'b0,32'd0,           1'b1,B+32'h104,        1'b0,32'd0);
    vt[16] = mk(1'b1,1'b1,inst_of(B+32'h104),1'b0,1'b0,32'd0,           1'b1,B+32'h108,        1'b0,32'd0);
    vt[17] = mk(1'b1,1'b1,J,                 1'b1,1'b1,B+32'h200,       1'b0,B+32'h10C,        1'b1,B+32'h104);
    vt[18] = mk(1'b1,1'b0,32'd0,             1'b1,1'b0,32'd0,           1'b1,B+32'h200,        1'b0,32'd0);
    vt[19] = mk(1'b0,1'b1,inst_of(B+32'h200),1'b1,1'b0,32'd0,           1'b1,B+32'h204,        1'b0,32'd0);
    vt[20] = mk(1'b0,1'b0,32'd0,             1'b1,1'b0,32'd0,           1'b1,B+32'h204,        1'b1,B+32'h200);
    vt[21] = mk(1'b0,1'b0,32'd0,             1'b0,1'b1,32'hFFFF_FFFC,   1'b0,B+32'h204,        1'b0,32'd0);
    vt[22] = mk(1'b1,1'b0,32'd0,             1'b0,1'b0,32'd0,           1'b1,32'hFFFF_FFFC,    1'b0,32'd0);
    vt[23] = mk(1'b0,1'b1,inst_of(32'hFFFF_FFFC),1'b1,1'b0,32'd0,       1'b1,32'h0000_0000,    1'b0,32'd0);
    vt[24] = mk(1'b0,1'b0,32'd0,             1'b1,1'b0,32'd0,           1'b1,32'h0000_0000,    1'b1,32'hFFFF_FFFC);

    rst_ni = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    epoch = 0; held = 0; pops = 0; exp_issue = B; exp_out = B; last_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_reset_outputs();

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 0) rst_ni = 1'b1;
      drive(vt[i].gnt, vt[i].rv, vt[i].rdata, vt[i].rdy, vt[i].redir, vt[i].rpc);
      #1;
      chk($sformatf("v%0d_req", i), 32'(bus.imem_req_o), 32'(vt[i].e_req));
      chk($sformatf("v%0d_addr", i), bus.imem_addr_o, vt[i].e_addr);
      chk($sformatf("v%0d_valid", i), 32'(bus.if_valid_o), 32'(vt[i].e_valid));
      if (vt[i].e_valid) begin
        chk($sformatf("v%0d_pc", i), bus.if_pc_o, vt[i].e_pc);
        chk($sformatf("v%0d_inst", i), bus.if_inst_o, vt[i].e_inst);
      end
    end

    // Decode stalled: FIFO fills to depth and requests stop
    do_reset();
    for (int i = 0; i < 10; i++) auto_cycle(100, 100, 0, 0);
    chk("fill_req_low", 32'(last_req), 32'd0);

    // Sustained one instruction per cycle with a 1-cycle memory
    p0 = pops;
    for (int i = 0; i < 20; i++) auto_cycle(100, 100, 100, 0);
    chk("throughput", 32'(pops - p0), 32'd20);

    for (int i = 0; i < 1500; i++) auto_cycle(70, 60, 70, 3);

    do_reset();
    for (int i = 0; i < 300; i++) auto_cycle(100, 100, 100, 0);
    chk("progress", 32'(pops > 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
